// File: rtl/wb_regfile_stage_pkg.sv
// Processor-wide constants shared by the register file, control unit and MEM/WB register.
// Holds datapath widths, the hardwired-zero register index and writeback-select encodings.
package wb_regfile_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic MEMTOREG_ALU = 1'b0;
  localparam logic MEMTOREG_MEM = 1'b1;

endpackage

// File: rtl/wb_regfile_stage_regfile.sv
// 2-read/1-write register array: async clear, combinational reads with r0 forced to zero.
// Latency: reads 0 cycles, write commits on the rising edge; no backpressure.
module regfile_2r1w
  import wb_regfile_stage_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_stage_pkg::DATA_W,
  parameter int ADDR_W   = wb_regfile_stage_pkg::ADDR_W,
  parameter int NUM_REGS = wb_regfile_stage_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  // Entry 0 is never read back, so whatever the caller drives at index 0 cannot leak out.
  always_comb begin
    readData1 = mem[readAddr1];
    readData2 = mem[readAddr2];
    if (readAddr1 == ADDR_W'(REG_ZERO)) readData1 = '0;
    if (readAddr2 == ADDR_W'(REG_ZERO)) readData2 = '0;
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects ALU/load result, commits to the register file, bypasses to ID reads.
// Latency: reads/bypass 0 cycles, commit and write counter on the next rising edge; no backpressure.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_stage_pkg::DATA_W,
  parameter int ADDR_W   = wb_regfile_stage_pkg::ADDR_W,
  parameter int NUM_REGS = wb_regfile_stage_pkg::NUM_REGS,
  parameter int COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  inALUResult,
  input  logic [DATA_W-1:0]  inReadData,
  input  logic [ADDR_W-1:0]  inWriteReg,
  input  logic               inMemToReg,
  input  logic               inRegWrite,
  input  logic [ADDR_W-1:0]  readReg1,
  input  logic [ADDR_W-1:0]  readReg2,
  output logic [DATA_W-1:0]  outReadData1,
  output logic [DATA_W-1:0]  outReadData2,
  output logic [DATA_W-1:0]  outWriteData,
  output logic               outWriteEn,
  output logic [COUNT_W-1:0] outWbCount
);

  logic [DATA_W-1:0] rfData1;
  logic [DATA_W-1:0] rfData2;

  assign outWriteData = (inMemToReg == MEMTOREG_MEM) ? inReadData : inALUResult;

  // Gating on inRegWrite first keeps an X destination index harmless while no write is requested.
  assign outWriteEn = rst & inRegWrite & (inWriteReg != ADDR_W'(REG_ZERO));

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) uRegfile (
    .clk       (clk),
    .rst       (rst),
    .writeEn   (outWriteEn),
    .writeAddr (inWriteReg),
    .writeData (outWriteData),
    .readAddr1 (readReg1),
    .readAddr2 (readReg2),
    .readData1 (rfData1),
    .readData2 (rfData2)
  );

  // Bypass never matches index 0 because outWriteEn already excludes it.
  always_comb begin
    outReadData1 = rfData1;
    outReadData2 = rfData2;
    if (outWriteEn && (readReg1 == inWriteReg)) outReadData1 = outWriteData;
    if (outWriteEn && (readReg2 == inWriteReg)) outReadData2 = outWriteData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outWbCount <= '0;
    end else if (outWriteEn) begin
      outWbCount <= outWbCount + COUNT_W'(1);
    end
  end

endmodule
